// File: rtl/count_capture_if.sv
// count_capture_if
// Valid/ready stream carrying captured count values out of count_capture.
//   out_data  : value at the FIFO head
//   out_valid : FIFO is non-empty, out_data is meaningful
//   out_ready : consumer accepts out_data this cycle
// Modports: master (count_capture side), slave (consumer side).
interface count_capture_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/count_capture.sv
// count_capture
// Timestamps rising edges of trigger against a free-running counter. Each
// edge pushes the current count into a DEPTH-entry FIFO, which is drained
// through a valid/ready stream.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous, active-high reset
//   count     : counter value to sample
//   trigger   : event line, captured on its rising edge
//   out_if    : stream (out_data / out_valid / out_ready), master side
//   full      : FIFO holds DEPTH entries
//   level     : number of occupied entries
//   overflow  : sticky, set when a capture was dropped; cleared by reset
//
// Build option:
//   COUNT_CAPTURE_DELTA_EN : store count minus the count of the previous
//                            detected edge instead of the absolute count.
module count_capture #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       count,
    input  logic                   trigger,
    count_capture_if.master        out_if,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             trigger_q;
    logic             trig_edge;
    logic             empty;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] cap_value;

    assign trig_edge = trigger & ~trigger_q;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign level     = wr_ptr - rd_ptr;

    assign out_if.out_valid = ~empty;
    assign out_if.out_data  = mem[rd_ptr[AW-1:0]];

    assign pop  = out_if.out_valid & out_if.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = trig_edge & (~full | pop);

`ifdef COUNT_CAPTURE_DELTA_EN
    logic [WIDTH-1:0] prev_cap;

    assign cap_value = count - prev_cap;

    // Updated on every detected edge, dropped or not, so deltas always refer
    // to the previous event rather than the previous stored entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_cap <= '0;
        end else if (trig_edge) begin
            prev_cap <= count;
        end
    end
`else
    assign cap_value = count;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // trigger_q resets high so a trigger already high at reset
            // release is not mistaken for an edge.
            trigger_q <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            trigger_q <= trigger;
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= cap_value;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (trig_edge && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: doc/count_capture.md
Name: count_capture

Overview:
- Downstream consumer of the free-running counter's `count` output.
- Timestamps events: on each rising edge of `trigger`, the current `count` value is pushed into a small FIFO.
- The FIFO is drained through a valid/ready stream.
- Used in the test designs to timestamp events against the counter and to check counter progression.

Parameters:
- WIDTH, 32: width of `count` and of the captured data.
- DEPTH, 4: number of FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- count  input  WIDTH  counter value to sample
- trigger  input  1  event line; a capture happens on its rising edge
- out_data  output  WIDTH  captured value at FIFO head
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts `out_data` this cycle
- full  output  1  FIFO holds DEPTH entries
- level  output  $clog2(DEPTH)+1  number of occupied entries
- overflow  output  1  sticky flag: a capture was dropped

Behaviour:
- Reset and clocking:
  - Reset `rst` is asynchronous and active-high.
  - All state is clocked on the rising edge of `clk`.
- Reset values:
  - Read/write pointers = 0, `level` = 0, `out_valid` = 0, `full` = 0, `overflow` = 0, `out_data` = 0.
  - `trigger_q` = 1, so a `trigger` held high across reset release is not a capture.
- Edge detect:
  - `trigger_q` is a register holding `trigger`; `edge = trigger & ~trigger_q`.
  - A level held high yields exactly one capture.
- Push:
  - On an `edge` cycle, the `count` value present in that cycle is written at the tail at the next clock edge.
  - `out_valid` rises the cycle after the edge, so capture latency = 1 cycle.
- Pop:
  - A pop happens when `out_valid & out_ready`; the head advances at the clock edge.
  - `out_data` is the head entry, driven combinationally from storage by the read pointer.
  - `out_data` is undefined-but-stable when `out_valid` = 0. It shows 0 after reset.
- Stream rules: once `out_valid` = 1, it and `out_data` hold until popped.
- Pointers:
  - Width $clog2(DEPTH)+1; they wrap naturally modulo 2*DEPTH.
  - Empty = pointers equal; full = indices equal and MSBs differ.
  - `level` = wr − rd, in pointer-width arithmetic.
- Simultaneous push and pop:
  - When not empty: both happen and `level` is unchanged.
  - When full: the pop frees a slot, the push is accepted, `level` stays DEPTH, `overflow` is unaffected.
  - When empty: only the push occurs; no same-cycle bypass, so `out_valid` rises the next cycle.
- Overflow:
  - An edge while full with no pop drops the capture; storage and pointers are unchanged.
  - `overflow` is set to 1 and stays 1 until reset.
- Reset mid-operation: all entries are discarded immediately (asynchronously); outputs take their reset values in the same cycle.
- Arithmetic: `count` is stored verbatim. No sign or width conversion.

Optional Feature:
- Macro: COUNT_CAPTURE_DELTA_EN.
- When defined:
  - Each stored value = `count` − `prev_cap`, modulo 2^WIDTH.
  - `prev_cap` is a WIDTH register reset to 0.
  - `prev_cap` is loaded with `count` on every detected edge, including dropped ones, so after an overflow the delta stays relative to the last event.
- When undefined: absolute `count` is stored and no `prev_cap` register exists.
- Ports are identical in both builds.

Test Plan:
1. Single capture: WIDTH=32, DEPTH=4, `out_ready`=0; `trigger` rises in the cycle where `count`=5.
   -> Next cycle: `out_valid`=1, `out_data`=5, `level`=1.
   -> Then `out_ready`=1 for 1 cycle -> `out_valid`=0, `level`=0.
2. Held trigger: `trigger` high for 10 cycles starting at `count`=20.
   -> Exactly one entry, value 20. `level`=1.
   -> `trigger` low 1 cycle then high again at `count`=31 -> second entry 31.
3. Overflow: `out_ready`=0; edges at `count` = 10, 12, 14, 16, 18.
   -> `full`=1 and `level`=4 after the 4th edge.
   -> `overflow`=1 after the 5th edge.
   -> Drain with `out_ready`=1 returns 10, 12, 14, 16, then `out_valid`=0.
   -> `overflow` remains 1.
4. Push and pop while full: FIFO full with 10, 12, 14, 16; edge at `count`=40 with `out_ready`=1 in the same cycle.
   -> `level` stays 4, `overflow` stays 0.
   -> Drain yields 12, 14, 16, 40.
5. Async reset mid-operation: `level`=3 and `overflow`=1; assert `rst` between clock edges.
   -> Same cycle: `out_valid`=0, `level`=0, `full`=0, `overflow`=0.
   -> `trigger` held high through the reset release produces no capture.
6. Delta mode (COUNT_CAPTURE_DELTA_EN defined): edges at `count` = 7, 20, 20+2^32−1 (wraps to 19).
   -> Outputs 7, 13, 0xFFFFFFFF.
